ex_mdu: RTL and testbench
=========================

# ex_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the operand and operation fields that the decode/execute pipeline register presents to the E stage, and it holds the architectural HI/LO registers. It runs multi-cycle MULT/MULTU/DIV/DIVU operations with a busy countdown, and it serves MFHI/MFLO/MTHI/MTLO. The hazard unit uses its `E_mdu_start`/`E_mdu_busy` outputs to stall MD-class instructions in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge; `reset==0` resets the block.
- `E_mdu_op`  in  4  operation code from the macro header: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; other codes behave as NONE.
- `E_rs_data`  in  32  forwarded rs operand (dividend, multiplicand, MTHI/MTLO source).
- `E_rt_data`  in  32  forwarded rt operand (divisor, multiplier).
- `E_mdu_start`  out  1  combinational; 1 when `E_mdu_op` is MULT/MULTU/DIV/DIVU and the unit is idle.
- `E_mdu_busy`  out  1  registered; 1 while a multi-cycle operation is in flight.
- `E_mdu_result`  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.

## Operation
- State: `HI`, `LO`, pending `p_hi`/`p_lo`, and down-counter `cnt` (4 bits minimum, sized to the maximum of the two parameters).
- Reset (`reset==0` at an edge) sets HI, LO, p_hi, p_lo and cnt to 0. Any in-flight operation is discarded. After reset, `E_mdu_busy`=0 and `E_mdu_result`=0.
- IDLE (`cnt==0`) with start op:
  - The result is computed from the operands at the start edge and stored in p_hi/p_lo.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES.
  - Operands are not needed after this edge.
- BUSY (`cnt!=0`): `cnt` decrements each edge. On the edge where `cnt` goes 1→0, HI<=p_hi and LO<=p_lo.
- Arithmetic rules:
  - MULT: 64-bit signed product of rs and rt; HI = bits 63:32, LO = bits 31:0.
  - MULTU: same split, unsigned product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Divisor 0 (DIV or DIVU): the busy period runs normally; HI and LO are unchanged at completion.
- MTHI/MTLO while idle: HI or LO <= rs at the edge.
- MFHI/MFLO read the current HI/LO with no stall.
- Any op other than NONE presented while busy is ignored (no state change), including start, MT and MF ops. The hazard unit guarantees this never happens; the bench treats a violation as an assertion failure.
- `E_mdu_start` is 0 while busy.

## Timing
- Start edge T: `E_mdu_busy`=1 during cycles T+1 … T+N, where N is the parameter for the op.
- HI/LO are updated at the end of cycle T+N. `E_mdu_busy`=0 and the new HI/LO are visible from cycle T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1.
- MTHI/MTLO at edge T: the new value is readable by MFHI/MFLO from cycle T+1.
- Reset low at any edge during BUSY: busy=0 in the next cycle; HI/LO=0, with no late write from the discarded operation.
- `E_mdu_result` has zero latency: it is combinational from `E_mdu_op`, HI and LO.

## Structure
- Shared macro header (`macros.v`) carries the MDU op encodings and the default cycle counts, for use by this block, the controller and the hazard unit.
- No sub-module is required. The multiply and divide are inline `$signed`/unsigned expressions evaluated at start. The counter, the pending registers and HI/LO live in a single sequential block.
- `E_mdu_start`/`E_mdu_busy` are exported for the hazard unit's stall equation: stall an MD-class instruction in D when `start | busy`.

## Test plan
- MULT rs=0xFFFFFFFF, rt=2, then NONE:
  - busy=1 for 5 cycles.
  - MFHI → 0xFFFFFFFF and MFLO → 0xFFFFFFFE from cycle T+6.
- MULTU rs=0xFFFFFFFF, rt=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=7, rt=0, with prior MTHI 0x1234 and MTLO 0x5678:
  - busy=1 for 10 cycles.
  - HI=0x1234 and LO=0x5678 are unchanged.
- MTLO rs=0xCAFEBABE at edge T, MFLO at T+1 → result 0xCAFEBABE. Then MULT 3×4, then a second MULT presented in cycle T+6: accepted, `E_mdu_start`=1, HI=0, LO=12 beforehand.
- DIV started, then `reset` driven low for one edge at the third busy cycle:
  - busy=0 next cycle and HI=LO=0.
  - No write occurs at the original completion cycle.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared MDU definitions: op encodings, default cycle counts and the
// start-edge arithmetic used to fill the pending HI/LO pair.
package ex_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // A zero divisor returns the current pair, so completion rewrites HI/LO
  // with the values they already hold.
  function automatic hilo_t mdu_calc(input logic [3:0] op, input logic [31:0] rs,
                                     input logic [31:0] rt, input hilo_t cur);
    logic signed [63:0] sp;
    logic [63:0]        up;
    hilo_t              r;
    r  = cur;
    sp = '0;
    up = '0;
    case (op)
      MDU_MULT: begin
        sp = $signed(rs) * $signed(rt);
        r  = '{hi: sp[63:32], lo: sp[31:0]};
      end
      MDU_MULTU: begin
        up = {32'b0, rs} * {32'b0, rt};
        r  = '{hi: up[63:32], lo: up[31:0]};
      end
      MDU_DIV: begin
        if (rt != 32'b0) begin
          if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
            r = '{hi: 32'b0, lo: 32'h8000_0000};
          else
            r = '{hi: $signed(rs) % $signed(rt), lo: $signed(rs) / $signed(rt)};
        end
      end
      MDU_DIVU: begin
        if (rt != 32'b0)
          r = '{hi: rs % rt, lo: rs / rt};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// E-stage multiply/divide unit: HI/LO registers, multi-cycle MULT/DIV with a
// busy countdown, and zero-latency MFHI/MFLO reads.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  output logic        E_mdu_start,
  output logic        E_mdu_busy,
  output logic [31:0] E_mdu_result
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = ($clog2(CNT_MAX + 1) > 4) ? $clog2(CNT_MAX + 1) : 4;

  logic [31:0]   hi, lo;
  hilo_t         p;
  logic [CW-1:0] cnt;
  logic          is_start, is_mul, idle;
  hilo_t         calc;

  assign idle     = (cnt == '0);
  assign is_mul   = (E_mdu_op == MDU_MULT) || (E_mdu_op == MDU_MULTU);
  assign is_start = is_mul || (E_mdu_op == MDU_DIV) || (E_mdu_op == MDU_DIVU);
  assign calc     = mdu_calc(E_mdu_op, E_rs_data, E_rt_data, '{hi: hi, lo: lo});

  assign E_mdu_start = is_start && idle;
  assign E_mdu_busy  = !idle;

  always_comb begin
    E_mdu_result = 32'b0;
    case (E_mdu_op)
      MDU_MFHI: E_mdu_result = hi;
      MDU_MFLO: E_mdu_result = lo;
      default:  ;
    endcase
  end

  // Ops arriving while busy are dropped; the hazard unit keeps them out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi  <= 32'b0;
      lo  <= 32'b0;
      p   <= '0;
      cnt <= '0;
    end else if (!idle) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi <= p.hi;
        lo <= p.lo;
      end
    end else if (is_start) begin
      p   <= calc;
      cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (E_mdu_op == MDU_MTHI) begin
      hi <= E_rs_data;
    end else if (E_mdu_op == MDU_MTLO) begin
      lo <= E_rs_data;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: each driven cycle queues its expected
// busy/start/result; a negedge monitor pops and compares.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_rs_data, E_rt_data;
  logic        E_mdu_start, E_mdu_busy;
  logic [31:0] E_mdu_result;

  typedef struct {
    logic        busy;
    logic        start;
    logic [31:0] res;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  ex_mdu dut (
    .clk(clk), .reset(reset), .E_mdu_op(E_mdu_op),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .E_mdu_start(E_mdu_start), .E_mdu_busy(E_mdu_busy), .E_mdu_result(E_mdu_result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (E_mdu_busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy: got %b want %b", e.name, E_mdu_busy, e.busy);
      end
      n_chk++;
      if (E_mdu_start !== e.start) begin
        n_fail++;
        $display("FAIL %s start: got %b want %b", e.name, E_mdu_start, e.start);
      end
      n_chk++;
      if (E_mdu_result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", e.name, E_mdu_result, e.res);
      end
      n_chk++;
      if (reset && E_mdu_busy === 1'b1 && E_mdu_op != MDU_NONE) begin
        n_fail++;
        $display("FAIL %s protocol: op %0d presented while busy", e.name, E_mdu_op);
      end
    end
  end

  // One cycle: drive inputs, queue expectation, advance past the edge.
  task automatic cyc(input string name, input logic [3:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic eb, input logic es,
                     input logic [31:0] er);
    E_mdu_op  = op;
    E_rs_data = rs;
    E_rt_data = rt;
    sb.push_back('{busy: eb, start: es, res: er, name: name});
    @(posedge clk);
    #1;
  endtask

  task automatic busy_n(input string name, input int n);
    for (int i = 0; i < n; i++) cyc(name, MDU_NONE, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    reset     = 1'b0;
    E_mdu_op  = MDU_NONE;
    E_rs_data = 32'h0;
    E_rt_data = 32'h0;
    @(posedge clk);
    #1;
    cyc("rst_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    cyc("rst_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // MULT -1 * 2
    cyc("mult_start", MDU_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 32'h0);
    busy_n("mult_busy", 5);
    cyc("mult_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    cyc("mult_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF * 2
    cyc("multu_start", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 32'h0);
    busy_n("multu_busy", 5);
    cyc("multu_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0001);
    cyc("multu_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFE);

    // DIV -7 / 2
    cyc("div_start", MDU_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b1, 32'h0);
    busy_n("div_busy", 10);
    cyc("div_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFD);
    cyc("div_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // DIV 7 / -2
    cyc("divn_start", MDU_DIV, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0);
    busy_n("divn_busy", 10);
    cyc("divn_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFD);
    cyc("divn_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0001);

    // DIV overflow corner
    cyc("divov_start", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
    busy_n("divov_busy", 10);
    cyc("divov_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0000);
    cyc("divov_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // DIVU by zero leaves HI/LO alone
    cyc("mthi", MDU_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("mthi_rd", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234);
    cyc("mtlo", MDU_MTLO, 32'h5678, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("divu0_start", MDU_DIVU, 32'h7, 32'h0, 1'b0, 1'b1, 32'h0);
    busy_n("divu0_busy", 10);
    cyc("divu0_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234);
    cyc("divu0_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h5678);

    // DIVU 100 / 7
    cyc("divu_start", MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 32'h0);
    busy_n("divu_busy", 10);
    cyc("divu_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'd14);
    cyc("divu_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'd2);

    // MTLO then immediate MFLO, then back-to-back MULTs
    cyc("mtlo2", MDU_MTLO, 32'hCAFE_BABE, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("mtlo2_rd", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFE_BABE);
    cyc("b2b_m1", MDU_MULT, 32'd3, 32'd4, 1'b0, 1'b1, 32'h0);
    busy_n("b2b_m1_busy", 5);
    cyc("b2b_m2", MDU_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 32'h0);
    busy_n("b2b_m2_busy", 5);
    cyc("b2b_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1);
    cyc("b2b_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset during DIV discards it
    cyc("rmid_mtlo", MDU_MTLO, 32'h55, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("rmid_start", MDU_DIV, 32'd100, 32'd7, 1'b0, 1'b1, 32'h0);
    busy_n("rmid_busy", 2);
    reset = 1'b0;
    busy_n("rmid_busy3", 1);
    reset = 1'b1;
    cyc("rmid_after_hi", MDU_MFHI, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("rmid_after_lo", MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      cyc("rmid_nowrite", (i % 2 == 0) ? MDU_MFHI : MDU_MFLO, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    cyc("idle_none", MDU_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
